// File: rtl/stopwatch_core.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_core
// Purpose  : Tick detect, button FSM and MM:SS.t BCD counter with lap hold.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_core #(
  parameter int SYNC_STAGES     = 2,
  parameter int TICKS_PER_COUNT = 1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       DIV_262144,
  input  logic       STRTSTOP,
  input  logic       LAP_LOAD,
  output logic [3:0] TENTHS,
  output logic [3:0] SEC_ONES,
  output logic [2:0] SEC_TENS,
  output logic [3:0] MIN_ONES,
  output logic [2:0] MIN_TENS,
  output logic       RUNNING,
  output logic       LAP_HELD,
  output logic       TICK,
  output logic       ROLLOVER
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAP  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0] mt;
    logic [3:0] mo;
    logic [2:0] st;
    logic [3:0] so;
    logic [3:0] t;
  } bcd_t;

  localparam logic [7:0] c_PRESC_MAX = 8'(TICKS_PER_COUNT - 1);

  state_t                 r_state, w_state_nxt;
  bcd_t                   r_cnt, r_lap, w_cnt_inc, w_disp;
  logic [7:0]             r_presc;
  logic                   r_div_q, r_tick, r_rollover;
  logic [SYNC_STAGES-1:0] r_ss_sync, r_ll_sync;
  logic                   r_ss_prev, r_ll_prev;
  logic                   w_tick_evt, w_ss_ev, w_ll_ev;
  logic                   w_cnt_en, w_advance, w_wrap;
  logic                   w_lap_load, w_clear;

  assign w_tick_evt = DIV_262144 & ~r_div_q;
  assign w_ss_ev    = r_ss_sync[SYNC_STAGES-1] & ~r_ss_prev;
  assign w_ll_ev    = r_ll_sync[SYNC_STAGES-1] & ~r_ll_prev;
  assign w_cnt_en   = ((r_state == S_RUN) || (r_state == S_LAP)) && w_tick_evt;
  assign w_advance  = w_cnt_en && (r_presc == c_PRESC_MAX);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_div_q   <= 1'b0;
      r_tick    <= 1'b0;
      r_ss_sync <= '0;
      r_ll_sync <= '0;
      r_ss_prev <= 1'b0;
      r_ll_prev <= 1'b0;
    end else begin
      r_div_q   <= DIV_262144;
      r_tick    <= w_tick_evt;
      r_ss_sync <= {r_ss_sync[SYNC_STAGES-2:0], STRTSTOP};
      r_ll_sync <= {r_ll_sync[SYNC_STAGES-2:0], LAP_LOAD};
      r_ss_prev <= r_ss_sync[SYNC_STAGES-1];
      r_ll_prev <= r_ll_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // STRTSTOP is tested first so a simultaneous LAP_LOAD edge is dropped
  always_comb begin
    w_state_nxt = r_state;
    w_lap_load  = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: if (w_ss_ev) w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_ss_ev) w_state_nxt = S_STOP;
        else if (w_ll_ev) begin
          w_state_nxt = S_LAP;
          w_lap_load  = 1'b1;
        end
      end
      S_LAP: begin
        if (w_ss_ev)      w_state_nxt = S_STOP;
        else if (w_ll_ev) w_state_nxt = S_RUN;
      end
      S_STOP: begin
        if (w_ss_ev) w_state_nxt = S_RUN;
        else if (w_ll_ev) begin
          w_state_nxt = S_IDLE;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_inc = r_cnt;
    w_wrap    = 1'b0;
    if (r_cnt.t != 4'd9) w_cnt_inc.t = r_cnt.t + 4'd1;
    else begin
      w_cnt_inc.t = 4'd0;
      if (r_cnt.so != 4'd9) w_cnt_inc.so = r_cnt.so + 4'd1;
      else begin
        w_cnt_inc.so = 4'd0;
        if (r_cnt.st != 3'd5) w_cnt_inc.st = r_cnt.st + 3'd1;
        else begin
          w_cnt_inc.st = 3'd0;
          if (r_cnt.mo != 4'd9) w_cnt_inc.mo = r_cnt.mo + 4'd1;
          else begin
            w_cnt_inc.mo = 4'd0;
            if (r_cnt.mt != 3'd5) w_cnt_inc.mt = r_cnt.mt + 3'd1;
            else begin
              w_cnt_inc.mt = 3'd0;
              w_wrap       = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_cnt      <= '0;
      r_lap      <= '0;
      r_presc    <= '0;
      r_rollover <= 1'b0;
    end else begin
      r_rollover <= w_advance && w_wrap;
      if (w_clear) begin
        r_cnt   <= '0;
        r_presc <= '0;
      end else if (r_state == S_IDLE) begin
        r_presc <= '0;
      end else if (w_cnt_en) begin
        if (w_advance) begin
          r_presc <= '0;
          r_cnt   <= w_cnt_inc;
        end else begin
          r_presc <= r_presc + 8'd1;
        end
      end
      if (w_lap_load) r_lap <= r_cnt;
    end
  end

  assign w_disp   = (r_state == S_LAP) ? r_lap : r_cnt;
  assign TENTHS   = w_disp.t;
  assign SEC_ONES = w_disp.so;
  assign SEC_TENS = w_disp.st;
  assign MIN_ONES = w_disp.mo;
  assign MIN_TENS = w_disp.mt;
  assign RUNNING  = (r_state == S_RUN) || (r_state == S_LAP);
  assign LAP_HELD = (r_state == S_LAP);
  assign TICK     = r_tick;
  assign ROLLOVER = r_rollover;

endmodule
`default_nettype wire
